// File: rtl/mips_pkg.sv
// Shared encodings, FSM state enum and ALU op type for the multicycle MIPS core.
package mips_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  // Instruction class; I_BAD (zero) is what an unrecognised opcode/funct decodes to.
  typedef enum logic [3:0] {
    I_BAD, I_ALU, I_ADDI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_JR
  } iclass_e;

  typedef struct packed {
    iclass_e cls;
    alu_op_e op;
  } dec_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  function automatic dec_t decode(input logic [31:0] ir);
    dec_t d;
    d.cls = I_BAD;
    d.op  = ALU_ADD;
    case (ir[31:26])
      OP_RTYPE: begin
        case (ir[5:0])
          FN_ADD: begin d.cls = I_ALU; d.op = ALU_ADD; end
          FN_SUB: begin d.cls = I_ALU; d.op = ALU_SUB; end
          FN_AND: begin d.cls = I_ALU; d.op = ALU_AND; end
          FN_OR:  begin d.cls = I_ALU; d.op = ALU_OR;  end
          FN_SLT: begin d.cls = I_ALU; d.op = ALU_SLT; end
          FN_JR:  d.cls = I_JR;
          default: d.cls = I_BAD;
        endcase
      end
      OP_ADDI: d.cls = I_ADDI;
      OP_LW:   d.cls = I_LW;
      OP_SW:   d.cls = I_SW;
      OP_BEQ:  d.cls = I_BEQ;
      OP_J:    d.cls = I_J;
      OP_JAL:  d.cls = I_JAL;
      default: d.cls = I_BAD;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32 x DATA_W register file: two combinational read ports, one synchronous write port.
// Register 0 is hardwired to zero; writes to it are dropped.
module mips_regfile #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd
);

  logic [31:0][DATA_W-1:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we && (wa != 5'd0)) regs_d[wa] = wd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs_q[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs_q[ra2];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB FSM with word-addressed PC.
// Define MIPS_MC_OVF_TRAP_EN to trap and halt on signed overflow of add/sub/addi.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              Clock,
  input  logic              Reset_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              retire,
  output logic              halt,
  output logic              trap,
  output logic [PC_W-1:0]   PC_out
);

  localparam logic [PC_W-1:0] JMASK = PC_W'({26{1'b1}});

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, npc_q, npc_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d, res_q, res_d;
  dec_t              dec_q, dec_d;
  logic              imem_req_q, imem_req_d, dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic [DATA_W-1:0] dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
  logic              retire_q, retire_d, halt_q, halt_d, trap_q, trap_d;

  logic [DATA_W-1:0] rd1, rd2, opnd, alu;
  logic [4:0]        rf_wa;
  logic              rf_we, ovf_trap;
  logic [PC_W-1:0]   pc1, br_tgt, j_tgt, jr_tgt;

  mips_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk   (Clock),
    .rst_n (Reset_n),
    .ra1   (ir_q[25:21]),
    .ra2   (ir_q[20:16]),
    .rd1   (rd1),
    .rd2   (rd2),
    .we    (rf_we),
    .wa    (rf_wa),
    .wd    (res_q)
  );

  // res_q carries the ALU result, the load data or the jal link value into WB.
  always_comb begin
    rf_we = (state_q == WB);
    rf_wa = ir_q[15:11];
    if (dec_q.cls == I_JAL)      rf_wa = 5'd31;
    else if (dec_q.cls != I_ALU) rf_wa = ir_q[20:16];
  end

  always_comb begin
    opnd = (dec_q.cls == I_ALU) ? b_q : imm_q;
    alu  = '0;
    case (dec_q.op)
      ALU_ADD: alu    = a_q + opnd;
      ALU_SUB: alu    = a_q - opnd;
      ALU_AND: alu    = a_q & opnd;
      ALU_OR:  alu    = a_q | opnd;
      ALU_SLT: alu[0] = ($signed(a_q) < $signed(opnd));
      default: alu    = '0;
    endcase
  end

`ifdef MIPS_MC_OVF_TRAP_EN
  logic add_ovf, sub_ovf;
  assign add_ovf  = (a_q[DATA_W-1] == opnd[DATA_W-1]) && (alu[DATA_W-1] != a_q[DATA_W-1]);
  assign sub_ovf  = (a_q[DATA_W-1] != opnd[DATA_W-1]) && (alu[DATA_W-1] != a_q[DATA_W-1]);
  assign ovf_trap = (dec_q.cls inside {I_ALU, I_ADDI}) &&
                    (((dec_q.op == ALU_ADD) && add_ovf) || ((dec_q.op == ALU_SUB) && sub_ovf));
`else
  assign ovf_trap = 1'b0;
`endif

  assign pc1    = pc_q + PC_W'(1);
  assign br_tgt = pc1 + PC_W'($signed(ir_q[15:0]));
  assign j_tgt  = (pc1 & ~JMASK) | PC_W'(ir_q[25:0]);
  assign jr_tgt = PC_W'(a_q);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    npc_d        = npc_q;
    ir_d         = ir_q;
    a_d          = a_q;
    b_d          = b_q;
    imm_d        = imm_q;
    res_d        = res_q;
    dec_d        = dec_q;
    imem_req_d   = imem_req_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    retire_d     = 1'b0;
    halt_d       = halt_q;
    trap_d       = trap_q;
    case (state_q)
      FETCH: begin
        // The request is raised one cycle after reset and kept up until accepted.
        imem_req_d = 1'b1;
        if (imem_req_q && imem_ready) begin
          ir_d       = imem_rdata;
          imem_req_d = 1'b0;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        a_d   = rd1;
        b_d   = rd2;
        imm_d = DATA_W'($signed(ir_q[15:0]));
        dec_d = decode(ir_q);
        if (dec_d.cls == I_BAD) begin
          halt_d  = 1'b1;
          state_d = HALT;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d = alu;
        npc_d = pc1;
        case (dec_q.cls)
          I_ALU, I_ADDI: begin
            if (ovf_trap) begin
              trap_d  = 1'b1;
              halt_d  = 1'b1;
              state_d = HALT;
            end else begin
              state_d = WB;
            end
          end
          I_LW, I_SW: begin
            dmem_req_d   = 1'b1;
            dmem_we_d    = (dec_q.cls == I_SW);
            dmem_addr_d  = a_q + imm_q;
            dmem_wdata_d = b_q;
            state_d      = MEM;
          end
          I_BEQ, I_J, I_JR: begin
            if (dec_q.cls == I_J)                       pc_d = j_tgt;
            else if (dec_q.cls == I_JR)                 pc_d = jr_tgt;
            else if ((dec_q.cls == I_BEQ) && (a_q == b_q)) pc_d = br_tgt;
            else                                        pc_d = pc1;
            retire_d   = 1'b1;
            imem_req_d = 1'b1;
            state_d    = FETCH;
          end
          I_JAL: begin
            res_d   = DATA_W'(pc1);
            npc_d   = j_tgt;
            state_d = WB;
          end
          default: begin
            halt_d  = 1'b1;
            state_d = HALT;
          end
        endcase
      end
      MEM: begin
        if (dmem_ready) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          if (dec_q.cls == I_SW) begin
            pc_d       = npc_q;
            retire_d   = 1'b1;
            imem_req_d = 1'b1;
            state_d    = FETCH;
          end else begin
            res_d   = dmem_rdata;
            state_d = WB;
          end
        end
      end
      WB: begin
        pc_d       = npc_q;
        retire_d   = 1'b1;
        imem_req_d = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      npc_q        <= RESET_PC;
      ir_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      imm_q        <= '0;
      res_q        <= '0;
      dec_q        <= '0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      retire_q     <= 1'b0;
      halt_q       <= 1'b0;
      trap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      npc_q        <= npc_d;
      ir_q         <= ir_d;
      a_q          <= a_d;
      b_q          <= b_d;
      imm_q        <= imm_d;
      res_q        <= res_d;
      dec_q        <= dec_d;
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      retire_q     <= retire_d;
      halt_q       <= halt_d;
      trap_q       <= trap_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign retire     = retire_q;
  assign halt       = halt_q;
  assign trap       = trap_q;
  assign PC_out     = pc_q;

endmodule

// File: doc/mips_multicycle_core.md
MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath and register width; legal values 16 and 32.
REQ-002 SHALL have parameter PC_W, default 32, word-address PC width.
REQ-003 SHALL have parameter RESET_PC, default 0, PC value loaded at reset.
REQ-004 SHALL have port Clock, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port Reset_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have ports imem_req (output, 1), imem_addr (output, PC_W), imem_ready (input, 1) and imem_rdata (input, 32) for instruction fetch.
REQ-007 SHALL have ports dmem_req (output, 1), dmem_we (output, 1), dmem_addr (output, DATA_W), dmem_wdata (output, DATA_W), dmem_ready (input, 1) and dmem_rdata (input, DATA_W) for data access.
REQ-008 SHALL have ports retire (output, 1, one-cycle pulse per completed instruction), halt (output, 1), trap (output, 1) and PC_out (output, PC_W, current PC).

Function
REQ-009 SHALL run FSM states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-010 SHALL, in FETCH, hold imem_req=1 and imem_addr=PC until imem_ready=1, then latch imem_rdata into IR and go to DECODE.
REQ-011 SHALL, in DECODE, latch GPR[rs] and GPR[rt] into A and B, and sign-extend imm16 to DATA_W.
REQ-012 SHALL, in EXEC, support add, sub, and, or, slt (funct 20/22/24/25/2A hex), jr, addi, lw, sw, beq, j and jal.
REQ-013 SHALL route paths in EXEC as follows: R-type and addi to WB; lw and sw to MEM; beq, j and jr update PC, pulse retire and go to FETCH; jal goes to WB.
REQ-014 SHALL compute next PC as PC+1 by default, PC+1+sext(imm) on taken beq, {PC+1[PC_W-1:26], IR[25:0]} on j/jal, and A[PC_W-1:0] on jr, with all arithmetic modulo 2^PC_W.
REQ-015 SHALL, in MEM, hold dmem_req=1, dmem_addr=A+sext(imm), dmem_we=(sw) and dmem_wdata=B until dmem_ready=1; sw then retires and goes to FETCH, lw goes to WB.
REQ-016 SHALL, in WB, write GPR[rd] (R-type), GPR[rt] (addi/lw) or GPR[31]=PC+1 (jal), update PC, pulse retire and go to FETCH.
REQ-017 SHALL read GPR[0] as 0 and ignore writes to it.
REQ-018 SHALL, on an unknown opcode or funct, enter HALT with halt=1, no register or memory write and no retire; HALT is left only by reset.
REQ-019 SHALL meet zero-wait-state latency of 4 cycles for R/addi/jal, 5 for lw, 4 for sw and 3 for beq/j/jr; each wait cycle adds exactly one cycle.
REQ-020 SHALL hold imem_req and dmem_req mutually exclusive, with each request's address and data stable while waiting.

Reset
REQ-021 SHALL, while Reset_n=0 at a rising edge, set PC=RESET_PC, state=FETCH, IR=0, all GPRs=0, and imem_req, dmem_req, dmem_we, retire, halt and trap all to 0.
REQ-022 SHALL let reset mid-transaction abandon the pending request the next cycle, with no GPR write.

Configuration
REQ-023 SHALL, with macro MIPS_MC_OVF_TRAP_EN defined, on signed overflow of add, sub or addi skip the write, set trap=1 and halt=1, and enter HALT.
REQ-024 SHALL, without MIPS_MC_OVF_TRAP_EN, write wrapped results and hold trap at 0.

Structure
REQ-025 SHALL place opcode/funct constants, the FSM state enum and the ALU-op typedef in shared package mips_pkg.
REQ-026 SHALL place the register file in sub-module mips_regfile (2 async read ports, 1 sync write port, DATA_W x 32).

Verification
REQ-027 SHALL cover: reset then addi $1,$0,5 with ready always 1 -> GPR1=5, retire in cycle 4, PC=1.
REQ-028 SHALL cover: sw $1,3($0) with dmem_ready delayed 3 cycles -> dmem_addr=3 and wdata=5 held stable, retire 3 cycles later.
REQ-029 SHALL cover: lw $2,3($0) returning 5, then beq $1,$2,-2 -> PC=PC+1-2, retire every instruction.
REQ-030 SHALL cover: jal to 0x10 then jr $31 -> GPR31=old PC+1, PC restored to it.
REQ-031 SHALL cover: add 0x7FFFFFFF+1 -> trap=1, halt=1 and GPR unchanged with macro defined; 0x80000000 written without it.
REQ-032 SHALL cover: opcode 3F hex -> halt=1 and no requests; Reset_n low asserted in MEM -> dmem_req=0 next cycle, PC=RESET_PC.
